m68k_bus_initiator: RTL and testbench
=====================================

Name: m68k_bus_initiator

Overview:
- 68030-style asynchronous bus master.
- Turns one request (address, size, direction, write data) into one or more AS_n/DS_n bus cycles terminated by DSACK0_n/DSACK1_n from the responder (DRAM controller, ROM, IO).
- Implements dynamic bus sizing: splits an operand across 8/16/32-bit ports, steers byte lanes and reassembles read data.
- Used by DMA and test masters in the Mackerel-30 PLD.

Parameters:
TIMEOUT_CYCLES, 255, CLK cycles in WAIT with no DSACK before the cycle aborts with error
DS_WR_DELAY, 1, CLK cycles between AS_n and DS_n assertion on writes (0-3)

Ports:
CLK  in  1  system clock (50 MHz)
RST_n  in  1  asynchronous active-low reset
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
req_rw  in  1  1 = read, 0 = write
req_size  in  2  operand size: 01 byte, 10 word, 11 3-byte, 00 long
req_addr  in  28  start byte address
req_wdata  in  32  write operand, right-aligned
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  valid with rsp_valid; 1 = BERR or timeout
rsp_rdata  out  32  read operand, right-aligned; zero on writes or errors
ADDR  out  28  bus address
RW  out  1  bus direction
SIZ0, SIZ1  out  1 each  remaining-byte count on the bus
AS_n, DS_n  out  1 each  address and data strobes
DATA_OUT  out  32  write data (D31 = lane 0)
DATA_OE  out  1  data bus drive enable
DATA_IN  in  32  read data
DSACK0_n, DSACK1_n  in  1 each  asynchronous termination and port width
BERR_n  in  1  asynchronous bus error

Behaviour:
- Reset (async, immediate): AS_n=DS_n=1, RW=1, DATA_OE=0, ADDR=0, SIZ=00, rsp_valid=0, rsp_err=0, rsp_rdata=0, state=IDLE. Reset mid-cycle negates strobes at once and discards the operand.
- DSACK0_n, DSACK1_n and BERR_n pass through 2-flop synchronizers before use.
- Registered state: cur_addr (28b), remaining (3b, 1-4), operand shift register, read accumulator.
- SIZ encodes remaining: 4→00, 3→11, 2→10, 1→01.
- States and transitions:
  - IDLE: on accept, load registers, go to SETUP.
  - SETUP: drive ADDR, SIZ and RW. On a write, drive DATA_OUT and set DATA_OE=1. Go to STROBE.
  - STROBE: AS_n=0. DS_n=0 the same cycle on reads, or after DS_WR_DELAY cycles on writes. Go to WAIT.
  - WAIT: a timeout counter runs. Exit on the first event present:
    1. synced BERR low → error;
    2. any synced DSACK low → TERM;
    3. counter == TIMEOUT_CYCLES → error.
    Both DSACKs high means keep waiting. BERR takes priority over a simultaneous DSACK.
  - TERM: on reads, capture DATA_IN this cycle. Negate AS_n and DS_n, set DATA_OE=0. Compute n (below). Set cur_addr += n, remaining -= n. Go to RECOVER.
  - RECOVER: wait until both synced DSACKs are high. Then go to SETUP if remaining > 0. Otherwise pulse rsp_valid and go to IDLE.
  - Error path: negate strobes, wait for synced DSACK/BERR release, pulse rsp_valid with rsp_err=1, go to IDLE.
- Port width from the synced DSACK pair (DSACK1,DSACK0 low=asserted):
  - both low: 32-bit port, n = min(remaining, 4 - A[1:0]);
  - DSACK1 only: 16-bit port, n = min(remaining, 2 - A[0]);
  - DSACK0 only: 8-bit port, n = 1.
- Write lane steering. b0..b3 are the next operand bytes, most significant first; A is cur_addr[1:0]. Lanes listed D31:24 to D7:0:
  - A=00: b0 b1 b2 b3
  - A=01: b0 b0 b1 b2
  - A=10: b0 b1 b0 b1
  - A=11: b0 b0 b1 b0
  - After each term, shift the operand left 8*n.
- Read lane capture:
  - 32-bit port: n bytes starting at lane A[1:0].
  - 16-bit port: n bytes starting at lane A[0] within D31:16.
  - 8-bit port: D31:24.
  - Each capture: accumulator = (accumulator << 8*n) | bytes. The final accumulator is right-aligned per req_size; upper bytes are zero.
- Address wraps modulo 2^28.

Decomposition:
- Package m68k_bus_pkg holds:
  - SIZ encodings (SIZ_BYTE, SIZ_WORD, SIZ_3BYTE, SIZ_LONG);
  - port-width codes (PORT8, PORT16, PORT32);
  - the state enum (IDLE, SETUP, STROBE, WAIT, TERM, RECOVER, ERROR);
  - n-bytes and SIZ-from-remaining functions.
- One combinational sub-module, m68k_byte_lanes: write steering and read extraction from (A, port width, n).

Test Plan:
- Long read at 0x0000100, 32-bit port (both DSACK), DATA_IN=0xDEADBEEF → 1 cycle, SIZ=00, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Long write 0x11223344 at 0x0000001, 8-bit port → 4 cycles at 0x01,0x02,0x03,0x04; SIZ 00,11,10,01; D31:24 = 11,22,33,44.
- Word read at 0x0000003, 16-bit port, bytes 0xAB then 0xCD → 2 cycles; rsp_rdata=0x0000ABCD.
- 3-byte write 0xA1B2C3 at 0x0000002, 32-bit port → cycle 1 DATA_OUT=A1B2A1B2 with n=2; cycle 2 at 0x04, SIZ=01, D31:24=C3.
- Responder never acknowledges → rsp_valid with rsp_err=1 after 255 WAIT cycles; AS_n high; req_ready returns high. BERR together with DSACK → error response.
- RST_n low in WAIT → AS_n, DS_n high and DATA_OE low the same cycle; no rsp_valid; after release, a new request completes normally.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// Shared encodings and helpers for the 68030-style bus initiator:
// SIZ codes, port widths, FSM states and byte-count arithmetic.
package m68k_bus_pkg;

   localparam logic [1:0] SIZ_LONG  = 2'b00;
   localparam logic [1:0] SIZ_BYTE  = 2'b01;
   localparam logic [1:0] SIZ_WORD  = 2'b10;
   localparam logic [1:0] SIZ_3BYTE = 2'b11;

   typedef enum logic [1:0] {
      PORT8  = 2'd0,
      PORT16 = 2'd1,
      PORT32 = 2'd2
   } port_t;

   typedef enum logic [2:0] {
      IDLE, SETUP, STROBE, WAIT, TERM, RECOVER, ERROR
   } state_t;

   // Bytes transferred by one bus cycle: limited by the port's remaining lanes.
   function automatic logic [2:0] n_bytes(input port_t port, input logic [1:0] a,
                                          input logic [2:0] rem);
      logic [2:0] room;
      case (port)
         PORT32:  room = 3'd4 - {1'b0, a};
         PORT16:  room = 3'd2 - {2'b00, a[0]};
         default: room = 3'd1;
      endcase
      return (rem < room) ? rem : room;
   endfunction

   // 4 maps to 00 naturally by truncation; 1..3 are their own SIZ code.
   function automatic logic [1:0] siz_from_rem(input logic [2:0] rem);
      return rem[1:0];
   endfunction

   function automatic logic [2:0] rem_from_siz(input logic [1:0] siz);
      return (siz == SIZ_LONG) ? 3'd4 : {1'b0, siz};
   endfunction

endpackage

// File: rtl/m68k_byte_lanes.sv
// Combinational byte-lane logic: write-data steering onto D31:0 and
// extraction of the n valid read bytes, right-aligned.
module m68k_byte_lanes
   import m68k_bus_pkg::*;
(
   input  logic [1:0]  i_a,
   input  port_t       i_port,
   input  logic [2:0]  i_n,
   input  logic [31:0] i_oper,
   input  logic [31:0] i_data_in,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rbytes
);

   logic [7:0] w_b0, w_b1, w_b2, w_b3;
   logic [1:0] w_lane;

   assign {w_b0, w_b1, w_b2, w_b3} = i_oper;

   always_comb begin
      o_wdata = {w_b0, w_b1, w_b2, w_b3};
      case (i_a)
         2'b00: o_wdata = {w_b0, w_b1, w_b2, w_b3};
         2'b01: o_wdata = {w_b0, w_b0, w_b1, w_b2};
         2'b10: o_wdata = {w_b0, w_b1, w_b0, w_b1};
         2'b11: o_wdata = {w_b0, w_b0, w_b1, w_b0};
         default: o_wdata = {w_b0, w_b1, w_b2, w_b3};
      endcase
   end

   // First valid lane (lane 0 = D31:24), then drop everything past n bytes.
   always_comb begin
      w_lane = 2'b00;
      case (i_port)
         PORT32:  w_lane = i_a;
         PORT16:  w_lane = {1'b0, i_a[0]};
         default: w_lane = 2'b00;
      endcase
      o_rbytes = (i_data_in << {w_lane, 3'b000}) >> {(3'd4 - i_n), 3'b000};
   end

endmodule

// File: rtl/m68k_bus_initiator.sv
// 68030-style asynchronous bus master with dynamic bus sizing: one request
// becomes one or more AS_n/DS_n cycles terminated by DSACK or BERR.
module m68k_bus_initiator
   import m68k_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int DS_WR_DELAY    = 1
) (
   input  logic        CLK,
   input  logic        RST_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rw,
   input  logic [1:0]  req_size,
   input  logic [27:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic [27:0] ADDR,
   output logic        RW,
   output logic        SIZ0,
   output logic        SIZ1,
   output logic        AS_n,
   output logic        DS_n,
   output logic [31:0] DATA_OUT,
   output logic        DATA_OE,
   input  logic [31:0] DATA_IN,
   input  logic        DSACK0_n,
   input  logic        DSACK1_n,
   input  logic        BERR_n
);

   localparam int         TW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [1:0] DLY_M1 = 2'(DS_WR_DELAY - 1);

   state_t        r_state;
   logic          r_ready;
   logic          r_rw;
   logic [27:0]   r_addr;
   logic [2:0]    r_rem;
   logic [31:0]   r_oper;
   logic [31:0]   r_acc;
   port_t         r_port;
   logic [TW-1:0] r_tmo;
   logic [1:0]    r_dly;
   logic [2:0]    r_sync1, r_sync2;

   logic          w_berr, w_dsack0, w_dsack1, w_ack;
   port_t         w_port_now;
   logic [2:0]    w_n;
   logic [31:0]   w_wdata, w_rbytes;

   assign req_ready = r_ready;

   // {BERR, DSACK1, DSACK0} through two flops before any decision uses them.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_sync1 <= 3'b111;
         r_sync2 <= 3'b111;
      end else begin
         r_sync1 <= {BERR_n, DSACK1_n, DSACK0_n};
         r_sync2 <= r_sync1;
      end
   end

   assign w_berr   = ~r_sync2[2];
   assign w_dsack1 = ~r_sync2[1];
   assign w_dsack0 = ~r_sync2[0];
   assign w_ack    = w_dsack0 | w_dsack1;

   always_comb begin
      w_port_now = PORT8;
      if (w_dsack1 && w_dsack0)
         w_port_now = PORT32;
      else if (w_dsack1)
         w_port_now = PORT16;
   end

   assign w_n = n_bytes(r_port, r_addr[1:0], r_rem);

   m68k_byte_lanes u_lanes (
      .i_a       (r_addr[1:0]),
      .i_port    (r_port),
      .i_n       (w_n),
      .i_oper    (r_oper),
      .i_data_in (DATA_IN),
      .o_wdata   (w_wdata),
      .o_rbytes  (w_rbytes)
   );

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_state   <= IDLE;
         r_ready   <= 1'b1;
         r_rw      <= 1'b1;
         r_addr    <= '0;
         r_rem     <= '0;
         r_oper    <= '0;
         r_acc     <= '0;
         r_port    <= PORT8;
         r_tmo     <= '0;
         r_dly     <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         ADDR      <= '0;
         RW        <= 1'b1;
         SIZ0      <= 1'b0;
         SIZ1      <= 1'b0;
         AS_n      <= 1'b1;
         DS_n      <= 1'b1;
         DATA_OUT  <= '0;
         DATA_OE   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid && r_ready) begin
                  r_ready <= 1'b0;
                  r_rw    <= req_rw;
                  r_addr  <= req_addr;
                  r_rem   <= rem_from_siz(req_size);
                  // Left-align the operand so b0 always sits in bits 31:24.
                  r_oper  <= req_wdata << {(3'd4 - rem_from_siz(req_size)), 3'b000};
                  r_acc   <= '0;
                  r_state <= SETUP;
               end
            end
            SETUP: begin
               ADDR         <= r_addr;
               {SIZ1, SIZ0} <= siz_from_rem(r_rem);
               RW           <= r_rw;
               if (!r_rw) begin
                  DATA_OUT <= w_wdata;
                  DATA_OE  <= 1'b1;
               end
               r_tmo   <= '0;
               r_dly   <= '0;
               r_state <= STROBE;
            end
            STROBE: begin
               AS_n <= 1'b0;
               if (r_rw || DS_WR_DELAY == 0)
                  DS_n <= 1'b0;
               r_state <= WAIT;
            end
            WAIT: begin
               if (DS_n) begin
                  r_dly <= r_dly + 2'd1;
                  if (r_dly == DLY_M1)
                     DS_n <= 1'b0;
               end
               if (w_berr) begin
                  AS_n    <= 1'b1;
                  DS_n    <= 1'b1;
                  DATA_OE <= 1'b0;
                  r_state <= ERROR;
               end else if (w_ack) begin
                  r_port  <= w_port_now;
                  r_state <= TERM;
               end else if (r_tmo == TW'(TIMEOUT_CYCLES)) begin
                  AS_n    <= 1'b1;
                  DS_n    <= 1'b1;
                  DATA_OE <= 1'b0;
                  r_state <= ERROR;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            TERM: begin
               AS_n    <= 1'b1;
               DS_n    <= 1'b1;
               DATA_OE <= 1'b0;
               r_acc   <= (r_acc << {w_n, 3'b000}) | w_rbytes;
               r_oper  <= r_oper << {w_n, 3'b000};
               r_addr  <= r_addr + {25'd0, w_n};
               r_rem   <= r_rem - w_n;
               r_state <= RECOVER;
            end
            RECOVER: begin
               if (!w_ack) begin
                  if (r_rem != 3'd0) begin
                     r_state <= SETUP;
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                     rsp_rdata <= r_rw ? r_acc : 32'd0;
                     r_ready   <= 1'b1;
                     r_state   <= IDLE;
                  end
               end
            end
            ERROR: begin
               if (r_sync2 == 3'b111) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  r_ready   <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Scoreboard bench for m68k_bus_initiator: a reactive responder checks each
// bus cycle, and a monitor checks every rsp_valid pulse against queued results.
module tb_m68k_bus_initiator;

   logic        CLK = 1'b0;
   logic        RST_n;
   logic        req_valid, req_ready, req_rw;
   logic [1:0]  req_size;
   logic [27:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [27:0] ADDR;
   logic        RW, SIZ0, SIZ1, AS_n, DS_n, DATA_OE;
   logic [31:0] DATA_OUT, DATA_IN;
   logic        DSACK0_n, DSACK1_n, BERR_n;

   m68k_bus_initiator #(.TIMEOUT_CYCLES(255), .DS_WR_DELAY(1)) dut (
      .CLK(CLK), .RST_n(RST_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .ADDR(ADDR), .RW(RW), .SIZ0(SIZ0), .SIZ1(SIZ1), .AS_n(AS_n), .DS_n(DS_n),
      .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DATA_IN(DATA_IN),
      .DSACK0_n(DSACK0_n), .DSACK1_n(DSACK1_n), .BERR_n(BERR_n)
   );

   always #10 CLK = ~CLK;

   // Responder action kinds
   localparam int A_NONE = 0, A_P8 = 1, A_P16 = 2, A_P32 = 3, A_BERR = 4;

   typedef struct { int kind; logic [31:0] din; } act_t;
   typedef struct { logic [27:0] addr; logic [1:0] siz; logic rw; logic [31:0] dout; } bus_t;
   typedef struct { logic err; logic [31:0] rdata; } rsp_t;

   act_t act_q[$];
   bus_t bus_q[$];
   rsp_t rsp_q[$];

   int total = 0;
   int bad   = 0;
   int rsp_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_bus(input logic [27:0] a, input logic [1:0] s, input logic rw,
                           input logic [31:0] d);
      bus_t b;
      b.addr = a; b.siz = s; b.rw = rw; b.dout = d;
      bus_q.push_back(b);
   endtask

   task automatic push_act(input int k, input logic [31:0] d);
      act_t a;
      a.kind = k; a.din = d;
      act_q.push_back(a);
   endtask

   task automatic push_rsp(input logic e, input logic [31:0] d);
      rsp_t r;
      r.err = e; r.rdata = d;
      rsp_q.push_back(r);
   endtask

   // Responder: reacts to both strobes low, checks the bus, then terminates.
   initial begin
      act_t a;
      bus_t b;
      DSACK0_n = 1'b1; DSACK1_n = 1'b1; BERR_n = 1'b1; DATA_IN = '0;
      forever begin
         @(negedge CLK);
         if (RST_n === 1'b1 && AS_n === 1'b0 && DS_n === 1'b0) begin
            if (act_q.size() == 0) begin
               total++; bad++;
               $display("FAIL bus_unexpected: got cycle at %h expected none", ADDR);
            end else begin
               a = act_q.pop_front();
               if (bus_q.size() != 0) begin
                  b = bus_q.pop_front();
                  chk("bus_addr", {4'h0, ADDR}, {4'h0, b.addr});
                  chk("bus_siz", {30'd0, SIZ1, SIZ0}, {30'd0, b.siz});
                  chk("bus_rw", {31'd0, RW}, {31'd0, b.rw});
                  if (!b.rw) begin
                     chk("bus_dout", DATA_OUT, b.dout);
                     chk("bus_oe", {31'd0, DATA_OE}, 32'd1);
                  end
               end
               DATA_IN = a.din;
               case (a.kind)
                  A_P8:   DSACK0_n = 1'b0;
                  A_P16:  DSACK1_n = 1'b0;
                  A_P32:  begin DSACK0_n = 1'b0; DSACK1_n = 1'b0; end
                  A_BERR: begin DSACK0_n = 1'b0; DSACK1_n = 1'b0; BERR_n = 1'b0; end
                  default: ;
               endcase
            end
            while (AS_n === 1'b0) @(negedge CLK);
            DSACK0_n = 1'b1; DSACK1_n = 1'b1; BERR_n = 1'b1;
         end
      end
   end

   // Monitor: every completion pulse must match the oldest queued response.
   always @(negedge CLK) begin
      if (RST_n === 1'b1 && rsp_valid === 1'b1) begin
         rsp_t r;
         rsp_cnt++;
         if (rsp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rsp_unexpected: got err=%b data=%h expected none", rsp_err, rsp_rdata);
         end else begin
            r = rsp_q.pop_front();
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
            chk("rsp_rdata", rsp_rdata, r.rdata);
         end
      end
   end

   task automatic issue(input logic rw, input logic [1:0] sz, input logic [27:0] a,
                        input logic [31:0] wd, input bit wait_rsp);
      int t;
      int start;
      t = 0;
      while (req_ready !== 1'b1 && t < 1000) begin @(negedge CLK); t++; end
      if (req_ready !== 1'b1) begin
         total++; bad++;
         $display("FAIL ready_timeout: got req_ready=%b expected 1", req_ready);
      end
      start = rsp_cnt;
      req_rw = rw; req_size = sz; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      @(negedge CLK);
      req_valid = 1'b0;
      chk("ready_busy", {31'd0, req_ready}, 32'd0);
      if (wait_rsp) begin
         t = 0;
         while (rsp_cnt == start && t < 2000) begin @(negedge CLK); t++; end
         if (rsp_cnt == start) begin
            total++; bad++;
            $display("FAIL rsp_timeout: got no response expected one within 2000 cycles");
         end
      end
   endtask

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      int cnt0;
      RST_n = 1'b0; req_valid = 1'b0; req_rw = 1'b1; req_size = 2'b00;
      req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge CLK);
      chk("rst_as", {31'd0, AS_n}, 32'd1);
      chk("rst_ds", {31'd0, DS_n}, 32'd1);
      chk("rst_rw", {31'd0, RW}, 32'd1);
      chk("rst_oe", {31'd0, DATA_OE}, 32'd0);
      chk("rst_addr", {4'h0, ADDR}, 32'd0);
      chk("rst_siz", {30'd0, SIZ1, SIZ0}, 32'd0);
      chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      RST_n = 1'b1;
      repeat (2) @(negedge CLK);

      // Long read, 32-bit port
      push_bus(28'h0000100, 2'b00, 1'b1, '0); push_act(A_P32, 32'hDEADBEEF);
      push_rsp(1'b0, 32'hDEADBEEF);
      issue(1'b1, 2'b00, 28'h0000100, '0, 1);

      // Long write at odd address, 8-bit port: four cycles
      push_bus(28'h0000001, 2'b00, 1'b0, 32'h11112233); push_act(A_P8, '0);
      push_bus(28'h0000002, 2'b11, 1'b0, 32'h22332233); push_act(A_P8, '0);
      push_bus(28'h0000003, 2'b10, 1'b0, 32'h33334433); push_act(A_P8, '0);
      push_bus(28'h0000004, 2'b01, 1'b0, 32'h44000000); push_act(A_P8, '0);
      push_rsp(1'b0, 32'h0);
      issue(1'b0, 2'b00, 28'h0000001, 32'h11223344, 1);

      // Word read at 0x3, 16-bit port: AB on D23:16, then CD on D31:24
      push_bus(28'h0000003, 2'b10, 1'b1, '0); push_act(A_P16, 32'h11AB2233);
      push_bus(28'h0000004, 2'b01, 1'b1, '0); push_act(A_P16, 32'hCD445566);
      push_rsp(1'b0, 32'h0000ABCD);
      issue(1'b1, 2'b10, 28'h0000003, '0, 1);

      // 3-byte write at 0x2, 32-bit port
      push_bus(28'h0000002, 2'b11, 1'b0, 32'hA1B2A1B2); push_act(A_P32, '0);
      push_bus(28'h0000004, 2'b01, 1'b0, 32'hC3000000); push_act(A_P32, '0);
      push_rsp(1'b0, 32'h0);
      issue(1'b0, 2'b11, 28'h0000002, 32'h00A1B2C3, 1);

      // Long read at 0x2 on 16-bit port: two word cycles
      push_bus(28'h0000002, 2'b00, 1'b1, '0); push_act(A_P16, 32'h1234ABCD);
      push_bus(28'h0000004, 2'b10, 1'b1, '0); push_act(A_P16, 32'h5678EEEE);
      push_rsp(1'b0, 32'h12345678);
      issue(1'b1, 2'b00, 28'h0000002, '0, 1);

      // Byte read at 0x7, 32-bit port: lane D7:0
      push_bus(28'h0000007, 2'b01, 1'b1, '0); push_act(A_P32, 32'h112233EE);
      push_rsp(1'b0, 32'h000000EE);
      issue(1'b1, 2'b01, 28'h0000007, '0, 1);

      // Byte write at 0x3, 32-bit port
      push_bus(28'h0000003, 2'b01, 1'b0, 32'h5A5A005A); push_act(A_P32, '0);
      push_rsp(1'b0, 32'h0);
      issue(1'b0, 2'b01, 28'h0000003, 32'h0000005A, 1);

      // Long read across the top of the address space, 8-bit port
      push_bus(28'hFFFFFFF, 2'b00, 1'b1, '0); push_act(A_P8, 32'h01AABBCC);
      push_bus(28'h0000000, 2'b11, 1'b1, '0); push_act(A_P8, 32'h02AABBCC);
      push_bus(28'h0000001, 2'b10, 1'b1, '0); push_act(A_P8, 32'h03AABBCC);
      push_bus(28'h0000002, 2'b01, 1'b1, '0); push_act(A_P8, 32'h04AABBCC);
      push_rsp(1'b0, 32'h01020304);
      issue(1'b1, 2'b00, 28'hFFFFFFF, '0, 1);

      // No acknowledge: timeout error
      push_bus(28'h0000010, 2'b00, 1'b1, '0); push_act(A_NONE, 32'hFFFFFFFF);
      push_rsp(1'b1, 32'h0);
      issue(1'b1, 2'b00, 28'h0000010, '0, 1);
      @(negedge CLK);
      chk("tmo_as", {31'd0, AS_n}, 32'd1);
      chk("tmo_ready", {31'd0, req_ready}, 32'd1);

      // BERR together with DSACK: error wins
      push_bus(28'h0000020, 2'b00, 1'b0, 32'h01020304); push_act(A_BERR, '0);
      push_rsp(1'b1, 32'h0);
      issue(1'b0, 2'b00, 28'h0000020, 32'h01020304, 1);

      // Reset while waiting for an acknowledge that never comes
      push_bus(28'h0000030, 2'b00, 1'b0, 32'hCAFEF00D); push_act(A_NONE, '0);
      cnt0 = rsp_cnt;
      issue(1'b0, 2'b00, 28'h0000030, 32'hCAFEF00D, 0);
      t = 0;
      while (DS_n !== 1'b0 && t < 100) begin @(negedge CLK); t++; end
      chk("mid_ds_low", {31'd0, DS_n}, 32'd0);
      repeat (5) @(negedge CLK);
      #3 RST_n = 1'b0;
      #1;
      chk("mid_as", {31'd0, AS_n}, 32'd1);
      chk("mid_ds", {31'd0, DS_n}, 32'd1);
      chk("mid_oe", {31'd0, DATA_OE}, 32'd0);
      repeat (2) @(negedge CLK);
      RST_n = 1'b1;
      repeat (3) @(negedge CLK);
      chk("mid_no_rsp", rsp_cnt, cnt0);

      push_bus(28'h0000100, 2'b00, 1'b1, '0); push_act(A_P32, 32'h0BADCAFE);
      push_rsp(1'b0, 32'h0BADCAFE);
      issue(1'b1, 2'b00, 28'h0000100, '0, 1);

      repeat (5) @(negedge CLK);
      chk("rsp_q_left", rsp_q.size(), 32'd0);
      chk("bus_q_left", bus_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
